button_debounce_multi: RTL and testbench
========================================

Name: button_debounce_multi

Overview:
- Parametrised, multi-channel debouncer for front-panel buttons and switches.
- Each channel synchronises its raw input, filters mechanical bounce, and publishes a stable level.
- Each channel also produces one-cycle press, release and long-press event pulses, with optional auto-repeat.
- Sits between board pins and user logic (LED/menu/counter FSMs), replacing per-button single-channel debouncers.

Parameters:
- NUM_CH, 4: number of independent channels.
- DEBOUNCE_TIME, 250_000: consecutive cycles of disagreement needed to accept a new level (10 ms at 25 MHz; 50 in simulation). Must be ≥1.
- LONG_PRESS_TIME, 25_000_000: cycles a debounced press must be held before o_Long_Pulse (1 s; 200 in simulation). Must be > DEBOUNCE_TIME.
- REPEAT_TIME, 0: 0 disables auto-repeat. Otherwise, after the long pulse, o_Long_Pulse re-fires every REPEAT_TIME cycles while the button is held.
- ACTIVE_LOW, 0: 1 inverts the raw inputs after synchronisation (pressed = pin low).

Ports:
- i_Clk, input, 1: 25 MHz system clock.
- i_Reset, input, 1: synchronous, active-high reset.
- i_Switch, input, NUM_CH: raw asynchronous button inputs, bit n = channel n.
- o_State, output, NUM_CH: debounced level (1 = pressed, after polarity correction).
- o_Press_Pulse, output, NUM_CH: 1-cycle pulse on an accepted 0→1 transition.
- o_Release_Pulse, output, NUM_CH: 1-cycle pulse on an accepted 1→0 transition.
- o_Long_Pulse, output, NUM_CH: 1-cycle pulse on long-press and on each auto-repeat.

Behaviour:
- Channels are fully independent. Identical per-channel logic is generated NUM_CH times; there is no shared counter.
- Synchroniser: two flops per channel. Polarity inversion (ACTIVE_LOW) is applied after the second flop. On reset the sync flops load the inactive raw level (0, or 1 if ACTIVE_LOW).
- Debounce counter:
  - Width is $clog2(DEBOUNCE_TIME+1).
  - If the synced level ≠ o_State, increment the counter.
  - On the cycle where the counter equals DEBOUNCE_TIME-1 and disagreement persists: o_State <= synced level, counter <= 0.
  - Any cycle of agreement clears the counter to 0 (bounce cancels).
  - The counter never wraps.
- Latency: o_State changes on rising edge DEBOUNCE_TIME+2, counting the first edge that samples the settled pin as edge 1.
- Event pulses:
  - o_Press_Pulse and o_Release_Pulse are registered and assert in the same cycle o_State takes its new value.
  - Each is high for exactly 1 cycle.
- Hold FSM per channel: RELEASED, PRESSED, LONG_HELD.
  - RELEASED → PRESSED on an accepted press; the hold counter is cleared.
  - PRESSED: the hold counter increments each cycle. When it equals LONG_PRESS_TIME-1, pulse o_Long_Pulse, go to LONG_HELD, and clear the hold counter. The first long pulse is therefore LONG_PRESS_TIME cycles after o_Press_Pulse.
  - LONG_HELD with REPEAT_TIME > 0: the hold counter counts to REPEAT_TIME-1, then pulses o_Long_Pulse and clears. It wraps indefinitely while the button is held.
  - LONG_HELD with REPEAT_TIME = 0: the counter stays idle; no further pulses.
  - PRESSED or LONG_HELD → RELEASED on an accepted release, with o_Release_Pulse. A release in the same cycle a long or repeat pulse would fire wins: no long pulse is issued.
  - Hold counter width is $clog2(max(LONG_PRESS_TIME, REPEAT_TIME)+1).
- Reset:
  - All outputs read 0 in the cycle after the reset edge; counters are 0 and the FSM is in RELEASED.
  - Reset mid-bounce or mid-hold discards all progress.
  - If a button is held through reset deassertion, a fresh o_Press_Pulse occurs after the full debounce latency.
- Simultaneous events on different channels are reported in the same cycle, each on its own bit.

Test Plan (sim params: NUM_CH=4, DEBOUNCE_TIME=50, LONG_PRESS_TIME=200):
- Clean press: ch0 0→1 held, sampled at edge 1 → o_State[0] and o_Press_Pulse[0] high at edge 52. The pulse is low again at edge 53. Other bits stay 0.
- Bounce rejection: ch1 toggles every 10 cycles for 300 cycles then settles to 1 → no pulse during bouncing; a single o_Press_Pulse[1] exactly 52 edges after the final settle.
- Long press: ch2 held 400 cycles with REPEAT_TIME=0 → one o_Long_Pulse[2] 200 cycles after o_Press_Pulse[2]. Release → o_Release_Pulse[2] 52 edges after the pin falls, with no further long pulses.
- Auto-repeat: REPEAT_TIME=40, ch3 held → long pulse at press+200, then pulses at press+240, +280, … Releasing stops them.
- Active-low/simultaneous: ACTIVE_LOW=1, idle pins high; pins 0 and 3 driven low on the same edge → o_Press_Pulse=4'b1001 in one cycle.
- Reset mid-operation: assert i_Reset at cycle 30 of a ch0 debounce, hold the pin high, deassert → all outputs 0 during reset. o_Press_Pulse[0] arrives 52 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/button_debounce_multi.sv
// Multi-channel button debouncer: per-channel two-flop synchroniser, bounce filter,
// press/release pulses and a hold FSM for long-press and auto-repeat pulses.
module button_debounce_multi #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_TIME   = 250_000,
  parameter int LONG_PRESS_TIME = 25_000_000,
  parameter int REPEAT_TIME     = 0,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_State,
  output logic [NUM_CH-1:0] o_Press_Pulse,
  output logic [NUM_CH-1:0] o_Release_Pulse,
  output logic [NUM_CH-1:0] o_Long_Pulse
);

  localparam int DW       = $clog2(DEBOUNCE_TIME + 1);
  localparam int HOLD_MAX = (LONG_PRESS_TIME > REPEAT_TIME) ? LONG_PRESS_TIME : REPEAT_TIME;
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam bit REP_EN   = (REPEAT_TIME > 0);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TIME - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_PRESS_TIME - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_TIME > 0) ? (REPEAT_TIME - 1) : 0);

  typedef enum logic [1:0] {
    S_RELEASED  = 2'd0,
    S_PRESSED   = 2'd1,
    S_LONG_HELD = 2'd2
  } hold_state_t;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic          r_sync1;
    logic          r_sync2;
    logic [DW-1:0] r_deb_cnt;
    logic          r_state;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic [HW-1:0] r_hold_cnt;
    logic [HW-1:0] w_hold_cnt_nxt;
    hold_state_t   r_hold_state;
    hold_state_t   w_hold_state_nxt;
    logic          w_level;
    logic          w_disagree;
    logic          w_accept;
    logic          w_press_ev;
    logic          w_release_ev;
    logic          w_long_fire;

    assign w_level      = r_sync2 ^ ACTIVE_LOW;
    assign w_disagree   = (w_level != r_state);
    assign w_accept     = w_disagree && (r_deb_cnt == DEB_LAST);
    assign w_press_ev   = w_accept && w_level;
    assign w_release_ev = w_accept && !w_level;

    // Synchroniser resets to the idle pin level so reset never looks like a press
    always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
        r_sync1 <= ACTIVE_LOW;
        r_sync2 <= ACTIVE_LOW;
      end else begin
        r_sync1 <= i_Switch[g];
        r_sync2 <= r_sync1;
      end
    end

    always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
        r_deb_cnt <= '0;
        r_state   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_press_ev;
        r_release <= w_release_ev;
        if (w_accept) begin
          r_deb_cnt <= '0;
          r_state   <= w_level;
        end else if (w_disagree) begin
          r_deb_cnt <= r_deb_cnt + DW'(1);
        end else begin
          r_deb_cnt <= '0;
        end
      end
    end

    always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
        r_hold_state <= S_RELEASED;
        r_hold_cnt   <= '0;
        r_long       <= 1'b0;
      end else begin
        r_hold_state <= w_hold_state_nxt;
        r_hold_cnt   <= w_hold_cnt_nxt;
        r_long       <= w_long_fire;
      end
    end

    always_comb begin
      w_hold_state_nxt = r_hold_state;
      case (r_hold_state)
        S_RELEASED: begin
          if (w_press_ev) w_hold_state_nxt = S_PRESSED;
          else            w_hold_state_nxt = S_RELEASED;
        end
        S_PRESSED: begin
          if (w_release_ev)                  w_hold_state_nxt = S_RELEASED;
          else if (r_hold_cnt == LONG_LAST)  w_hold_state_nxt = S_LONG_HELD;
          else                               w_hold_state_nxt = S_PRESSED;
        end
        S_LONG_HELD: begin
          if (w_release_ev) w_hold_state_nxt = S_RELEASED;
          else              w_hold_state_nxt = S_LONG_HELD;
        end
        default: w_hold_state_nxt = S_RELEASED;
      endcase
    end

    // A release accepted on the same edge suppresses any long/repeat pulse
    always_comb begin
      w_long_fire    = 1'b0;
      w_hold_cnt_nxt = '0;
      case (r_hold_state)
        S_RELEASED: begin
          w_hold_cnt_nxt = '0;
        end
        S_PRESSED: begin
          if (w_release_ev) begin
            w_hold_cnt_nxt = '0;
          end else if (r_hold_cnt == LONG_LAST) begin
            w_long_fire    = 1'b1;
            w_hold_cnt_nxt = '0;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + HW'(1);
          end
        end
        S_LONG_HELD: begin
          if (w_release_ev || !REP_EN) begin
            w_hold_cnt_nxt = '0;
          end else if (r_hold_cnt == REP_LAST) begin
            w_long_fire    = 1'b1;
            w_hold_cnt_nxt = '0;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + HW'(1);
          end
        end
        default: begin
          w_long_fire    = 1'b0;
          w_hold_cnt_nxt = '0;
        end
      endcase
    end

    assign o_State[g]         = r_state;
    assign o_Press_Pulse[g]   = r_press;
    assign o_Release_Pulse[g] = r_release;
    assign o_Long_Pulse[g]    = r_long;
  end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Scoreboard bench: dut0 is active-high without repeat, dut1 is active-low with REPEAT_TIME=40.
module tb_button_debounce_multi;

  logic       clk;
  logic       rst0, rst1;
  logic [3:0] sw0, sw1;
  logic [3:0] st0, pr0, rl0, lg0;
  logic [3:0] st1, pr1, rl1, lg1;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct packed {
    int         cyc;
    int         dut;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
    logic [3:0] state;
  } exp_t;

  exp_t exp_q[$];

  button_debounce_multi #(.NUM_CH(4), .DEBOUNCE_TIME(50), .LONG_PRESS_TIME(200),
                          .REPEAT_TIME(0), .ACTIVE_LOW(1'b0)) dut0 (
    .i_Clk(clk), .i_Reset(rst0), .i_Switch(sw0), .o_State(st0),
    .o_Press_Pulse(pr0), .o_Release_Pulse(rl0), .o_Long_Pulse(lg0));

  button_debounce_multi #(.NUM_CH(4), .DEBOUNCE_TIME(50), .LONG_PRESS_TIME(200),
                          .REPEAT_TIME(40), .ACTIVE_LOW(1'b1)) dut1 (
    .i_Clk(clk), .i_Reset(rst1), .i_Switch(sw1), .o_State(st1),
    .o_Press_Pulse(pr1), .o_Release_Pulse(rl1), .o_Long_Pulse(lg1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input int d, input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] l, input logic [3:0] s);
    exp_t e;
    e.cyc = c; e.dut = d; e.press = p; e.rel = r; e.lng = l; e.state = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input int d);
    logic [15:0] got;
    got = (d == 0) ? {st0, pr0, rl0, lg0} : {st1, pr1, rl1, lg1};
    checks++;
    if (got !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs dut%0d cyc %0d: got %h, expected 0000", d, cyc, got);
    end
  endtask

  // Monitor: pops expected events due this cycle; any other pulse is unexpected
  always @(negedge clk) begin : mon
    exp_t        e;
    logic        hit0, hit1;
    logic [15:0] got, want;
    hit0 = 1'b0;
    hit1 = 1'b0;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL missed_event dut%0d: expected at cyc %0d, now %0d", e.dut, e.cyc, cyc);
      end else begin
        if (e.dut == 0) begin
          hit0 = 1'b1;
          got  = {pr0, rl0, lg0, st0};
        end else begin
          hit1 = 1'b1;
          got  = {pr1, rl1, lg1, st1};
        end
        want = {e.press, e.rel, e.lng, e.state};
        if (got !== want) begin
          errors++;
          $display("FAIL event dut%0d cyc %0d: got press/rel/long/state %h, expected %h",
                   e.dut, cyc, got, want);
        end
      end
    end
    if (!hit0 && ((pr0 | rl0 | lg0) != 4'b0000)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse dut0 cyc %0d: press %b rel %b long %b", cyc, pr0, rl0, lg0);
    end
    if (!hit1 && ((pr1 | rl1 | lg1) != 4'b0000)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse dut1 cyc %0d: press %b rel %b long %b", cyc, pr1, rl1, lg1);
    end
  end

  initial begin : stim
    int c;
    int p;
    rst0 = 1'b1;
    rst1 = 1'b1;
    sw0  = 4'b0000;
    sw1  = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      chk_reset(0);
      chk_reset(1);
    end
    rst0 = 1'b0;
    rst1 = 1'b0;
    wait_cyc(5);

    // Clean press on ch0, released before the long-press point
    c = cyc; sw0[0] = 1'b1;
    push(c + 52, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    wait_cyc(100);
    c = cyc; sw0[0] = 1'b0;
    push(c + 52, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    wait_cyc(60);

    // Bounce on ch1: 10-cycle toggles never reach the threshold
    for (int i = 0; i < 30; i++) begin
      sw0[1] = (i % 2 == 0);
      wait_cyc(10);
    end
    c = cyc; sw0[1] = 1'b1;
    push(c + 52, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    wait_cyc(60);
    c = cyc; sw0[1] = 1'b0;
    push(c + 52, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    wait_cyc(60);

    // Long press on ch2 without repeat
    c = cyc; sw0[2] = 1'b1;
    push(c + 52,  0, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    push(c + 252, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    wait_cyc(400);
    c = cyc; sw0[2] = 1'b0;
    push(c + 52, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    wait_cyc(300);

    // Reset 30 cycles into a ch0 debounce with the pin held high
    sw0[0] = 1'b1;
    wait_cyc(30);
    rst0 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_reset(0);
    end
    rst0 = 1'b0;
    c = cyc;
    push(c + 52, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    wait_cyc(60);
    c = cyc; sw0[0] = 1'b0;
    push(c + 52, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    wait_cyc(60);

    // Active-low: pins 0 and 3 pulled low together
    c = cyc; sw1 = 4'b0110;
    push(c + 52, 1, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
    wait_cyc(60);
    c = cyc; sw1 = 4'b1111;
    push(c + 52, 1, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
    wait_cyc(60);

    // Auto-repeat on ch3; release lands exactly on a repeat slot and must win
    c = cyc; sw1[3] = 1'b0;
    p = c + 52;
    push(p, 1, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
    for (int k = 0; k < 4; k++)
      push(p + 200 + 40 * k, 1, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
    wait_cyc(360);
    c = cyc; sw1[3] = 1'b1;
    push(c + 52, 1, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    wait_cyc(100);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d expected events never seen, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
